pkt_switch_nport: RTL and testbench
===================================

# pkt_switch_nport

Parametrised N-port single-beat packet switch that generalises the 4-port switch datapath carried by `port_if`. Each input port has its own FIFO. Each output port has a round-robin arbiter and a one-entry output register with sink back-pressure. Illegal packets are dropped with per-port counters. The block sits between the per-port packet VCs/drivers and their sinks, replacing the fixed 4-port core.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of ports, 2..16.
- `DATA_W`, 8: payload width.
- `FIFO_DEPTH`, 4: entries per input FIFO; power of 2, ≥2.
- `ALLOW_SELF`, 1: 1 = a packet may target its own input port; 0 = such packets are dropped.
- `CNT_W`, 8: drop counter width.
- `PID_W`, derived localparam: `$clog2(NUM_PORTS)`, minimum 1.

Ports (port p occupies slice p of every flat bus):
- `clk` in 1: single clock; all state on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `valid_in` in NUM_PORTS: input packet valid.
- `source_in` in NUM_PORTS*PID_W: source field.
- `target_in` in NUM_PORTS*PID_W: destination port.
- `data_in` in NUM_PORTS*DATA_W: payload.
- `ready` out NUM_PORTS: input accepts this cycle.
- `valid_out` out NUM_PORTS: output register holds a packet.
- `source_out` out NUM_PORTS*PID_W: source field, passed through unchanged.
- `target_out` out NUM_PORTS*PID_W: target field, passed through unchanged.
- `data_out` out NUM_PORTS*DATA_W: payload.
- `out_ready` in NUM_PORTS: sink accepts the output register.
- `drop_cnt` out NUM_PORTS*CNT_W: per-input count of dropped packets, saturating.

## Operation
- **Input handshake:** a transfer occurs on any edge where `valid_in[p] && ready[p]`. The source holds its fields while `!ready[p]`.
- **Ready:** `ready[p] = !full[p] && !rst`. It depends only on registered state, never on `valid_in`.
- **Drop rule:** a transfer is illegal if `target_in >= NUM_PORTS`, or if `ALLOW_SELF==0 && target_in == p`.
  - The transfer is accepted (handshake completes) but nothing is written to the FIFO.
  - `drop_cnt[p]` increments and saturates at 2^CNT_W-1.
- **Input FIFO:** stores {source, target, data}.
  - Pointers are PID-independent, with an extra wrap bit for full/empty.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop occurs only on a grant.
- **Arbitration:** per output o, the requesters are the inputs whose FIFO is non-empty and whose head target is o.
  - A grant is issued when output register o is empty or being drained this cycle (`valid_out[o] && out_ready[o]`).
  - The winner is the first requester at or after `rr_ptr[o]`, wrapping modulo NUM_PORTS.
  - On a grant, `rr_ptr[o]` becomes winner+1, mod NUM_PORTS; without a grant it holds.
  - An input head has exactly one target, so an input is popped at most once per cycle.
- **Output register:**
  - Loads the winner's fields on a grant.
  - If drained with no grant, `valid_out` clears.
  - Holds its contents stably while `valid_out && !out_ready`.
- **Ordering:** packets from one input to one output are delivered in input order. Between inputs, service is round-robin fair.

## Timing
- **Reset (async assert, sync release):**
  - All FIFO pointers 0, and every entry is treated as empty.
  - `valid_out`, `source_out`, `target_out`, `data_out` are 0.
  - `drop_cnt` is 0 and every `rr_ptr` is 0.
  - `ready` is 0 while `rst` is high and 1 on the first cycle after release.
  - Assertion mid-packet discards everything in flight.
- **Latency:** a packet sampled at edge N into an empty FIFO, with output o idle, is granted at edge N+1. `valid_out[o]` is high in the cycle after N+1, giving 2 cycles with no bypass.
- **Throughput:** each output delivers 1 packet/cycle while `out_ready` is held high. Each input sustains 1 packet/cycle when its targets are not contended.
- **Full FIFO:** `ready[p]` falls on the edge where the count reaches FIFO_DEPTH. It rises the cycle after the first pop.

## Test plan
- **Reset:** assert `rst` asynchronously mid-traffic.
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release, `ready=4'b1111`, `drop_cnt=0`, no `valid_out`.
- **Single packet:** port 1 sends source=1, target=3, data=0xA5 at edge N.
  - `valid_out[3]` is high exactly 2 cycles later, carrying 1/3/0xA5.
  - No other `valid_out` asserts.
- **Contention:** ports 0, 1 and 2 each send one packet to target 3 on the same edge, with `out_ready[3]=1`.
  - Output 3 presents sources 0, 1, 2 on 3 consecutive cycles.
  - `rr_ptr[3]` ends at 3.
- **Back-pressure:** set `out_ready[2]=0`; port 0 sends 6 packets to port 2 with data 0..5 (FIFO_DEPTH=4).
  - Data 0 is held in output register 2 and data 1..4 fill the FIFO.
  - `ready[0]` drops after the 5th transfer, so data 5 stalls.
  - Raising `out_ready` delivers 0..5 in order, one per cycle.
- **Drops:**
  - NUM_PORTS=3, port 0 sends target=3: no output, `drop_cnt[0]=1`.
  - ALLOW_SELF=0, port 2 sends target=2: no output, `drop_cnt[2]` increments.
  - 300 illegal packets: `drop_cnt` reads 255.
- **Permutation throughput:** mapping 0→1, 1→2, 2→3, 3→0, driven every cycle for 100 cycles.
  - 400 packets delivered with `ready` constantly 1.
  - Scoreboard matches all 400 packets in order.

Source files
------------

// File: rtl/pkt_switch_nport_if.sv
// rtl/pkt_switch_nport_if.sv - flat per-port packet bus between drivers/sinks and pkt_switch_nport
// Port p occupies slice p of every bus; master is the driver/sink side, slave is the switch.
interface pkt_switch_nport_if #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 8,
   parameter int PID_W     = 2,
   parameter int CNT_W     = 8
);
   logic [NUM_PORTS-1:0]        valid_in;
   logic [NUM_PORTS*PID_W-1:0]  source_in;
   logic [NUM_PORTS*PID_W-1:0]  target_in;
   logic [NUM_PORTS*DATA_W-1:0] data_in;
   logic [NUM_PORTS-1:0]        ready;
   logic [NUM_PORTS-1:0]        valid_out;
   logic [NUM_PORTS*PID_W-1:0]  source_out;
   logic [NUM_PORTS*PID_W-1:0]  target_out;
   logic [NUM_PORTS*DATA_W-1:0] data_out;
   logic [NUM_PORTS-1:0]        out_ready;
   logic [NUM_PORTS*CNT_W-1:0]  drop_cnt;

   modport master (
      output valid_in, source_in, target_in, data_in, out_ready,
      input  ready, valid_out, source_out, target_out, data_out, drop_cnt
   );

   modport slave (
      input  valid_in, source_in, target_in, data_in, out_ready,
      output ready, valid_out, source_out, target_out, data_out, drop_cnt
   );
endinterface

// File: rtl/pkt_switch_nport.sv
// rtl/pkt_switch_nport.sv - N-port single-beat packet switch
// Per-input FIFOs, per-output round-robin arbiter feeding a one-entry output register.
module pkt_switch_nport #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int ALLOW_SELF = 1,
   parameter int CNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   pkt_switch_nport_if.slave bus
);
   localparam int PID_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int EW    = 2 * PID_W + DATA_W;

   typedef logic [PID_W-1:0] pid_t;
   typedef logic [EW-1:0]    entry_t;

   entry_t               mem      [NUM_PORTS][FIFO_DEPTH];
   logic [AW:0]          wr_ptr   [NUM_PORTS];
   logic [AW:0]          rd_ptr   [NUM_PORTS];
   logic [CNT_W-1:0]     dcnt     [NUM_PORTS];
   pid_t                 rr_ptr   [NUM_PORTS];
   entry_t               oreg     [NUM_PORTS];
   logic [NUM_PORTS-1:0] vout;

   entry_t               in_ent   [NUM_PORTS];
   entry_t               head     [NUM_PORTS];
   pid_t                 head_tgt [NUM_PORTS];
   pid_t                 win      [NUM_PORTS];
   logic [NUM_PORTS-1:0] full;
   logic [NUM_PORTS-1:0] empty;
   logic [NUM_PORTS-1:0] rdy;
   logic [NUM_PORTS-1:0] illegal;
   logic [NUM_PORTS-1:0] push;
   logic [NUM_PORTS-1:0] drop;
   logic [NUM_PORTS-1:0] grant;
   logic [NUM_PORTS-1:0] pop;

   // Entry layout is {source, target, data}; the extra pointer bit separates full from empty.
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         in_ent[p]   = {bus.source_in[p*PID_W +: PID_W], bus.target_in[p*PID_W +: PID_W],
                        bus.data_in[p*DATA_W +: DATA_W]};
         full[p]     = (wr_ptr[p][AW] != rd_ptr[p][AW]) &&
                       (wr_ptr[p][AW-1:0] == rd_ptr[p][AW-1:0]);
         empty[p]    = (wr_ptr[p] == rd_ptr[p]);
         rdy[p]      = !full[p] && !rst;
         illegal[p]  = (int'(bus.target_in[p*PID_W +: PID_W]) >= NUM_PORTS) ||
                       ((ALLOW_SELF == 0) && (int'(bus.target_in[p*PID_W +: PID_W]) == p));
         push[p]     = bus.valid_in[p] && rdy[p] && !illegal[p];
         drop[p]     = bus.valid_in[p] && rdy[p] && illegal[p];
         head[p]     = mem[p][rd_ptr[p][AW-1:0]];
         head_tgt[p] = head[p][DATA_W +: PID_W];
      end
   end

   // Each head has exactly one target, so at most one output can pop a given input.
   always_comb begin
      int idx;
      idx  = 0;
      pop  = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         grant[o] = 1'b0;
         win[o]   = '0;
         for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(rr_ptr[o]) + k) % NUM_PORTS;
            if (!grant[o] && (!vout[o] || bus.out_ready[o]) && !empty[idx] &&
                (int'(head_tgt[idx]) == o)) begin
               grant[o] = 1'b1;
               win[o]   = pid_t'(idx);
            end
         end
         if (grant[o]) pop[int'(win[o])] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            wr_ptr[p] <= '0;
            rd_ptr[p] <= '0;
            dcnt[p]   <= '0;
            rr_ptr[p] <= '0;
            oreg[p]   <= '0;
         end
         vout <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
            if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
            if (drop[p] && (dcnt[p] != '1)) dcnt[p] <= dcnt[p] + 1'b1;
            if (grant[p]) begin
               vout[p]   <= 1'b1;
               oreg[p]   <= head[win[p]];
               rr_ptr[p] <= (int'(win[p]) == NUM_PORTS - 1) ? '0 : pid_t'(win[p] + 1'b1);
            end else if (bus.out_ready[p]) begin
               vout[p]   <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (push[p]) mem[p][wr_ptr[p][AW-1:0]] <= in_ent[p];
      end
   end

   assign bus.ready     = rdy;
   assign bus.valid_out = vout;

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
      assign bus.source_out[g*PID_W +: PID_W]  = oreg[g][DATA_W+PID_W +: PID_W];
      assign bus.target_out[g*PID_W +: PID_W]  = oreg[g][DATA_W +: PID_W];
      assign bus.data_out[g*DATA_W +: DATA_W]  = oreg[g][DATA_W-1:0];
      assign bus.drop_cnt[g*CNT_W +: CNT_W]    = dcnt[g];
   end
endmodule

// File: tb/tb_pkt_switch_nport.sv
// tb/tb_pkt_switch_nport.sv - self-checking bench for pkt_switch_nport
// Directed scenarios plus random traffic against a per-(source,target) ordered scoreboard.
module tb_pkt_switch_nport;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pkt_switch_nport_if #(.NUM_PORTS(4), .DATA_W(8), .PID_W(2), .CNT_W(8)) bus ();
   pkt_switch_nport_if #(.NUM_PORTS(3), .DATA_W(8), .PID_W(2), .CNT_W(8)) bus3 ();

   pkt_switch_nport #(.NUM_PORTS(4), .DATA_W(8), .FIFO_DEPTH(4), .ALLOW_SELF(1), .CNT_W(8))
      dut (.clk(clk), .rst(rst), .bus(bus));
   pkt_switch_nport #(.NUM_PORTS(3), .DATA_W(8), .FIFO_DEPTH(4), .ALLOW_SELF(0), .CNT_W(8))
      dut3 (.clk(clk), .rst(rst), .bus(bus3));

   typedef struct packed {
      logic [1:0] s;
      logic [1:0] t;
      logic [7:0] d;
   } pkt_t;

   pkt_t       sb[$];
   int         checks    = 0;
   int         failures  = 0;
   bit         sb_on     = 1'b0;
   int         delivered = 0;
   int         pushed    = 0;
   logic [3:0] sent_v    = '0;
   bit         all_rdy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] dout(input int o);
      return bus.data_out[o*8 +: 8];
   endfunction
   function automatic logic [1:0] sout(input int o);
      return bus.source_out[o*2 +: 2];
   endfunction
   function automatic logic [1:0] tout(input int o);
      return bus.target_out[o*2 +: 2];
   endfunction
   function automatic logic [7:0] dcnt3(input int p);
      return bus3.drop_cnt[p*8 +: 8];
   endfunction

   task automatic drive(input int p, input logic v, input logic [1:0] s,
                        input logic [1:0] t, input logic [7:0] d);
      bus.valid_in[p]       = v;
      bus.source_in[p*2 +: 2] = s;
      bus.target_in[p*2 +: 2] = t;
      bus.data_in[p*8 +: 8]   = d;
   endtask

   task automatic drive3(input int p, input logic v, input logic [1:0] s,
                         input logic [1:0] t, input logic [7:0] d);
      bus3.valid_in[p]         = v;
      bus3.source_in[p*2 +: 2] = s;
      bus3.target_in[p*2 +: 2] = t;
      bus3.data_in[p*8 +: 8]   = d;
   endtask

   // Snapshot handshakes just before the edge, advance one clock, then check held outputs.
   task automatic tick();
      logic [3:0]  hold_v;
      logic [11:0] hold_f [4];
      pkt_t        e;
      int          idx;
      sent_v = bus.valid_in & bus.ready;
      hold_v = bus.valid_out & ~bus.out_ready;
      for (int o = 0; o < 4; o++) hold_f[o] = {sout(o), tout(o), dout(o)};
      if (sb_on) begin
         for (int p = 0; p < 4; p++) begin
            if (sent_v[p]) begin
               e.s = bus.source_in[p*2 +: 2];
               e.t = bus.target_in[p*2 +: 2];
               e.d = bus.data_in[p*8 +: 8];
               sb.push_back(e);
               pushed++;
            end
         end
         for (int o = 0; o < 4; o++) begin
            if (bus.valid_out[o] && bus.out_ready[o]) begin
               idx = -1;
               for (int i = 0; i < sb.size(); i++)
                  if (idx < 0 && sb[i].s == sout(o) && sb[i].t == 2'(o)) idx = i;
               chk("sb_found", {31'd0, idx >= 0}, 32'd1);
               if (idx >= 0) begin
                  chk("sb_data", {24'd0, dout(o)}, {24'd0, sb[idx].d});
                  sb.delete(idx);
               end
               delivered++;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int o = 0; o < 4; o++)
         if (hold_v[o]) chk("hold", {19'd0, bus.valid_out[o], sout(o), tout(o), dout(o)},
                            {19'd0, 1'b1, hold_f[o]});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.valid_in   = '0;
      bus.out_ready  = '1;
      bus3.valid_in  = '0;
      bus3.out_ready = '1;
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
   endtask

   initial begin
      bus.valid_in  = '0; bus.source_in  = '0; bus.target_in  = '0; bus.data_in  = '0;
      bus.out_ready = '1;
      bus3.valid_in = '0; bus3.source_in = '0; bus3.target_in = '0; bus3.data_in = '0;
      bus3.out_ready = '1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {28'd0, bus.ready}, 32'd0);
      chk("rst_vout", {28'd0, bus.valid_out}, 32'd0);
      chk("rst_dcnt", bus.drop_cnt, 32'd0);
      rst = 1'b0;
      #1;
      chk("rel_ready", {28'd0, bus.ready}, 32'hF);

      // Single packet, two-cycle latency
      drive(1, 1'b1, 2'd1, 2'd3, 8'hA5);
      tick();
      drive(1, 1'b0, 2'd0, 2'd0, 8'h00);
      chk("single_lat1", {28'd0, bus.valid_out}, 32'd0);
      tick();
      chk("single_vout", {28'd0, bus.valid_out}, 32'b1000);
      chk("single_fields", {20'd0, sout(3), tout(3), dout(3)}, {20'd0, 2'd1, 2'd3, 8'hA5});
      tick();
      chk("single_drain", {28'd0, bus.valid_out}, 32'd0);

      // Contention on output 3
      do_reset();
      for (int p = 0; p < 3; p++) drive(p, 1'b1, 2'(p), 2'd3, 8'(8'h10 + p));
      tick();
      for (int p = 0; p < 3; p++) drive(p, 1'b0, 2'd0, 2'd0, 8'h00);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("cont_vout", {28'd0, bus.valid_out}, 32'b1000);
         chk("cont_src", {30'd0, sout(3)}, 32'(k));
      end
      tick();
      chk("cont_idle", {28'd0, bus.valid_out}, 32'd0);
      chk("rr_ptr3", {30'd0, dut.rr_ptr[3]}, 32'd3);

      // Back-pressure on output 2
      do_reset();
      bus.out_ready[2] = 1'b0;
      for (int d = 0; d < 5; d++) begin
         chk("bp_ready", {31'd0, bus.ready[0]}, 32'd1);
         drive(0, 1'b1, 2'd0, 2'd2, 8'(d));
         tick();
      end
      chk("bp_full", {31'd0, bus.ready[0]}, 32'd0);
      drive(0, 1'b1, 2'd0, 2'd2, 8'd5);
      repeat (3) tick();
      chk("bp_stall", {31'd0, bus.ready[0]}, 32'd0);
      chk("bp_head", {23'd0, bus.valid_out[2], dout(2)}, {23'd0, 1'b1, 8'd0});
      bus.out_ready[2] = 1'b1;
      tick();
      chk("bp_d1", {24'd0, dout(2)}, 32'd1);
      chk("bp_reopen", {31'd0, bus.ready[0]}, 32'd1);
      tick();
      chk("bp_d5_sent", {31'd0, sent_v[0]}, 32'd1);
      drive(0, 1'b0, 2'd0, 2'd0, 8'h00);
      for (int k = 2; k < 6; k++) begin
         chk("bp_order", {23'd0, bus.valid_out[2], dout(2)}, {23'd0, 1'b1, 8'(k)});
         tick();
      end
      chk("bp_empty", {28'd0, bus.valid_out}, 32'd0);

      // Asynchronous reset in the middle of traffic
      bus.out_ready = '0;
      drive(0, 1'b1, 2'd0, 2'd1, 8'h33);
      drive(3, 1'b1, 2'd3, 2'd0, 8'h44);
      tick();
      tick();
      chk("pre_arst_vout", {28'd0, bus.valid_out}, 32'b0011);
      #2 rst = 1'b1;
      #1;
      chk("arst_vout", {28'd0, bus.valid_out}, 32'd0);
      chk("arst_dout", bus.data_out, 32'd0);
      chk("arst_src", {24'd0, bus.source_out}, 32'd0);
      chk("arst_ready", {28'd0, bus.ready}, 32'd0);
      bus.valid_in  = '0;
      bus.out_ready = '1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("arst_rel_ready", {28'd0, bus.ready}, 32'hF);
      chk("arst_rel_dcnt", bus.drop_cnt, 32'd0);
      tick();
      tick();
      chk("arst_no_leftover", {28'd0, bus.valid_out}, 32'd0);

      // Drops on the 3-port, no-self instance
      chk("d3_ready", {29'd0, bus3.ready}, 32'b111);
      drive3(0, 1'b1, 2'd0, 2'd3, 8'h11);
      tick();
      drive3(0, 1'b0, 2'd0, 2'd0, 8'h00);
      tick();
      tick();
      chk("drop_range_vout", {29'd0, bus3.valid_out}, 32'd0);
      chk("drop_range_cnt", {8'd0, bus3.drop_cnt}, 32'h000001);
      drive3(2, 1'b1, 2'd2, 2'd2, 8'h22);
      tick();
      drive3(2, 1'b0, 2'd0, 2'd0, 8'h00);
      tick();
      tick();
      chk("drop_self_vout", {29'd0, bus3.valid_out}, 32'd0);
      chk("drop_self_cnt", {8'd0, bus3.drop_cnt}, 32'h010001);
      drive3(2, 1'b1, 2'd2, 2'd0, 8'h5A);
      tick();
      drive3(2, 1'b0, 2'd0, 2'd0, 8'h00);
      tick();
      chk("d3_legal", {21'd0, bus3.valid_out, bus3.data_out[7:0]}, {21'd0, 3'b001, 8'h5A});
      drive3(1, 1'b1, 2'd1, 2'd3, 8'h77);
      for (int i = 0; i < 300; i++) begin
         tick();
         if (i == 253) chk("drop_254", {24'd0, dcnt3(1)}, 32'd254);
      end
      drive3(1, 1'b0, 2'd0, 2'd0, 8'h00);
      tick();
      chk("drop_sat", {24'd0, dcnt3(1)}, 32'd255);
      chk("drop_sat_ready", {29'd0, bus3.ready}, 32'b111);

      // Permutation throughput
      do_reset();
      sb_on     = 1'b1;
      delivered = 0;
      pushed    = 0;
      all_rdy   = 1'b1;
      for (int c = 0; c < 100; c++) begin
         for (int p = 0; p < 4; p++) drive(p, 1'b1, 2'(p), 2'((p + 1) % 4), 8'($urandom));
         if (bus.ready != 4'hF) all_rdy = 1'b0;
         tick();
      end
      bus.valid_in = '0;
      for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
      chk("perm_ready", {31'd0, all_rdy}, 32'd1);
      chk("perm_count", delivered, 32'd400);
      chk("perm_sb_empty", sb.size(), 32'd0);

      // Random traffic with random sink back-pressure
      delivered = 0;
      pushed    = 0;
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < 4; p++)
            if (!(bus.valid_in[p] && !sent_v[p]))
               drive(p, $urandom_range(0, 3) != 0, 2'(p), 2'($urandom_range(0, 3)), 8'($urandom));
         bus.out_ready = 4'($urandom);
         tick();
      end
      bus.valid_in  = '0;
      bus.out_ready = '1;
      for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
      chk("rand_sb_empty", sb.size(), 32'd0);
      chk("rand_count", delivered, pushed);
      sb_on = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
